// File: rtl/hazard_ctrl.sv
// Pipeline hazard / control unit for a 5-stage in-order core.
// Drives the write-enable and bubble/flush inputs of the IF_ID and ID_EX stage
// registers plus the PC write enable. Handles load-use stalls, EX-resolved
// redirects and a permanent halt on a retiring EBREAK. Also keeps saturating
// performance counters for stalls, flushes and retirements.
module hazard_ctrl #(
    parameter int LU_STALL_CYCLES = 1,
    parameter int CNT_W           = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic             id_uses_rs1,
    input  logic             id_uses_rs2,
    input  logic [4:0]       ex_rd,
    input  logic             ex_is_load,
    input  logic             ex_nop,
    input  logic             ex_redirect,
    input  logic             wb_valid,
    input  logic             wb_ebreak,
    output logic             pc_we,
    output logic             if_id_we,
    output logic             if_id_nop,
    output logic             id_ex_we,
    output logic             id_ex_nop,
    output logic             halted,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt,
    output logic [CNT_W-1:0] retired_cnt
);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        LU_STALL = 2'd1,
        HALT     = 2'd2
    } state_t;

    // Bubbles still owed after the first one, loaded when a stall starts.
    localparam logic [1:0] REM_INIT = 2'(LU_STALL_CYCLES - 1);

    state_t     state_reg, state_next;
    logic [1:0] rem_reg, rem_next;
    logic       halted_reg;

    logic       haz;
    logic       halt_trig;
    logic       stall_inc;
    logic       flush_inc;
    logic       retire_inc;

    // Index 0 = stall, 1 = flush, 2 = retired.
    logic [2:0]            cnt_inc;
    logic [2:0][CNT_W-1:0] cnt_val;

    // Load in EX whose destination is a live source of the instruction in ID.
    assign haz = ex_is_load & ~ex_nop & (ex_rd != 5'd0) &
                 ((id_uses_rs1 & (id_rs1 == ex_rd)) |
                  (id_uses_rs2 & (id_rs2 == ex_rd)));

    assign halt_trig = wb_valid & wb_ebreak;

    // Control outputs and next state; priority is halt > redirect > load-use.
    always_comb begin
        pc_we      = 1'b1;
        if_id_we   = 1'b1;
        if_id_nop  = 1'b0;
        id_ex_we   = 1'b1;
        id_ex_nop  = 1'b0;
        state_next = state_reg;
        rem_next   = rem_reg;
        stall_inc  = 1'b0;
        flush_inc  = 1'b0;

        if (rst) begin
            pc_we      = 1'b0;
            if_id_we   = 1'b0;
            id_ex_we   = 1'b0;
            state_next = RUN;
            rem_next   = 2'd0;
        end else if (state_reg == HALT || halt_trig) begin
            // Freeze the front end and bubble anything younger than EBREAK.
            pc_we      = 1'b0;
            if_id_we   = 1'b0;
            id_ex_we   = 1'b0;
            id_ex_nop  = 1'b1;
            state_next = HALT;
        end else if (ex_redirect) begin
            // Squash the two wrong-path instructions in IF_ID and ID_EX.
            if_id_nop  = 1'b1;
            id_ex_nop  = 1'b1;
            id_ex_we   = 1'b0;
            flush_inc  = 1'b1;
            state_next = RUN;
        end else if (state_reg == LU_STALL || haz) begin
            pc_we     = 1'b0;
            if_id_we  = 1'b0;
            id_ex_we  = 1'b0;
            id_ex_nop = 1'b1;
            stall_inc = 1'b1;
            if (state_reg == LU_STALL) begin
                if (rem_reg <= 2'd1) begin
                    state_next = RUN;
                    rem_next   = 2'd0;
                end else begin
                    rem_next = rem_reg - 2'd1;
                end
            end else if (LU_STALL_CYCLES > 1) begin
                state_next = LU_STALL;
                rem_next   = REM_INIT;
            end
        end
    end

    // FSM state, remaining-bubble counter and sticky halt flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg  <= RUN;
            rem_reg    <= 2'd0;
            halted_reg <= 1'b0;
        end else begin
            state_reg  <= state_next;
            rem_reg    <= rem_next;
            halted_reg <= (state_next == HALT);
        end
    end

    assign halted = halted_reg;

    // Retirements are counted in every state, including the EBREAK itself.
    assign retire_inc = wb_valid;
    assign cnt_inc    = {retire_inc, flush_inc, stall_inc};

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_cnt
            logic [CNT_W-1:0] cnt_reg;

            // Saturating event counter.
            always_ff @(posedge clk) begin
                if (rst) begin
                    cnt_reg <= '0;
                end else if (cnt_inc[gi] && (cnt_reg != {CNT_W{1'b1}})) begin
                    cnt_reg <= cnt_reg + CNT_W'(1);
                end
            end

            assign cnt_val[gi] = cnt_reg;
        end
    endgenerate

    assign stall_cnt   = cnt_val[0];
    assign flush_cnt   = cnt_val[1];
    assign retired_cnt = cnt_val[2];

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl. Two instances share the stimulus:
// dut_a (LU_STALL_CYCLES=1, CNT_W=32) and dut_b (LU_STALL_CYCLES=2, CNT_W=4).
// Each directed vector pushes its hand-computed expected outputs; a monitor
// pops on the falling edge and compares.
module tb_hazard_ctrl;

    localparam int CW_B = 4;

    // Control word: {pc_we, if_id_we, if_id_nop, id_ex_we, id_ex_nop, halted}
    localparam logic [5:0] C_RST   = 6'b000000;
    localparam logic [5:0] C_RSTH  = 6'b000001;
    localparam logic [5:0] C_RUN   = 6'b110100;
    localparam logic [5:0] C_STALL = 6'b000010;
    localparam logic [5:0] C_FLUSH = 6'b111010;
    localparam logic [5:0] C_HALT  = 6'b000011;

    localparam int P_IDLE      = 0;
    localparam int P_HAZ       = 1;
    localparam int P_HAZ_RS2   = 2;
    localparam int P_LD_X0     = 3;
    localparam int P_LD_NOP    = 4;
    localparam int P_REDIR_HAZ = 5;
    localparam int P_NOUSE     = 6;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] id_rs1, id_rs2, ex_rd;
    logic       id_uses_rs1, id_uses_rs2, ex_is_load, ex_nop, ex_redirect;
    logic       wb_valid, wb_ebreak;

    logic pc_we_a, if_id_we_a, if_id_nop_a, id_ex_we_a, id_ex_nop_a, halted_a;
    logic pc_we_b, if_id_we_b, if_id_nop_b, id_ex_we_b, id_ex_nop_b, halted_b;
    logic [31:0]     stall_a, flush_a, retired_a;
    logic [CW_B-1:0] stall_b, flush_b, retired_b;

    always #5 clk = ~clk;

    hazard_ctrl #(.LU_STALL_CYCLES(1), .CNT_W(32)) dut_a (
        .clk(clk), .rst(rst),
        .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
        .ex_rd(ex_rd), .ex_is_load(ex_is_load), .ex_nop(ex_nop),
        .ex_redirect(ex_redirect), .wb_valid(wb_valid), .wb_ebreak(wb_ebreak),
        .pc_we(pc_we_a), .if_id_we(if_id_we_a), .if_id_nop(if_id_nop_a),
        .id_ex_we(id_ex_we_a), .id_ex_nop(id_ex_nop_a), .halted(halted_a),
        .stall_cnt(stall_a), .flush_cnt(flush_a), .retired_cnt(retired_a)
    );

    hazard_ctrl #(.LU_STALL_CYCLES(2), .CNT_W(CW_B)) dut_b (
        .clk(clk), .rst(rst),
        .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
        .ex_rd(ex_rd), .ex_is_load(ex_is_load), .ex_nop(ex_nop),
        .ex_redirect(ex_redirect), .wb_valid(wb_valid), .wb_ebreak(wb_ebreak),
        .pc_we(pc_we_b), .if_id_we(if_id_we_b), .if_id_nop(if_id_nop_b),
        .id_ex_we(id_ex_we_b), .id_ex_nop(id_ex_nop_b), .halted(halted_b),
        .stall_cnt(stall_b), .flush_cnt(flush_b), .retired_cnt(retired_b)
    );

    typedef struct {
        int         idx;
        logic [5:0] ca;
        logic [5:0] cb;
        int         sa, fa, ra, sb, fb, rb;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;
    int   vec_idx  = 0;

    task automatic chk(input string name, input int idx, input int act, input int exp_v);
        checks++;
        if (act != exp_v) begin
            failures++;
            $display("FAIL %s vec=%0d actual=%0h expected=%0h", name, idx, act, exp_v);
        end
    endtask

    // Monitor: compare both instances against the oldest pending expectation.
    initial begin
        exp_t e;
        logic [5:0] ca, cb;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e  = exp_q.pop_front();
                ca = {pc_we_a, if_id_we_a, if_id_nop_a, id_ex_we_a, id_ex_nop_a, halted_a};
                cb = {pc_we_b, if_id_we_b, if_id_nop_b, id_ex_we_b, id_ex_nop_b, halted_b};
                chk("ctrl_a",    e.idx, int'(ca), int'(e.ca));
                chk("ctrl_b",    e.idx, int'(cb), int'(e.cb));
                chk("stall_a",   e.idx, int'(stall_a), e.sa);
                chk("flush_a",   e.idx, int'(flush_a), e.fa);
                chk("retired_a", e.idx, int'(retired_a), e.ra);
                chk("stall_b",   e.idx, int'(stall_b), e.sb);
                chk("flush_b",   e.idx, int'(flush_b), e.fb);
                chk("retired_b", e.idx, int'(retired_b), e.rb);
                $display("vec %0d ctrl_a=%b ctrl_b=%b a(s=%0d f=%0d r=%0d) b(s=%0d f=%0d r=%0d)",
                         e.idx, ca, cb, stall_a, flush_a, retired_a, stall_b, flush_b, retired_b);
            end
        end
    end

    task automatic step(input int pat, input bit wbv, input bit wbe, input bit r,
                        input logic [5:0] ca, input logic [5:0] cb,
                        input int sa, input int fa, input int ra,
                        input int sb, input int fb, input int rb);
        exp_t e;
        @(posedge clk);
        #1;
        rst         = r;
        wb_valid    = wbv;
        wb_ebreak   = wbe;
        id_rs1      = 5'd1;
        id_rs2      = 5'd2;
        id_uses_rs1 = 1'b1;
        id_uses_rs2 = 1'b1;
        ex_rd       = 5'd7;
        ex_is_load  = 1'b0;
        ex_nop      = 1'b0;
        ex_redirect = 1'b0;
        case (pat)
            P_HAZ, P_LD_NOP, P_REDIR_HAZ, P_NOUSE: begin
                // lw x5 in EX, add x6,x5,x1 in ID
                ex_rd      = 5'd5;
                ex_is_load = 1'b1;
                id_rs1     = 5'd5;
                id_rs2     = 5'd1;
                if (pat == P_LD_NOP)    ex_nop = 1'b1;
                if (pat == P_REDIR_HAZ) ex_redirect = 1'b1;
                if (pat == P_NOUSE)     id_uses_rs1 = 1'b0;
            end
            P_HAZ_RS2: begin
                ex_rd      = 5'd9;
                ex_is_load = 1'b1;
                id_rs1     = 5'd3;
                id_rs2     = 5'd9;
            end
            P_LD_X0: begin
                ex_rd      = 5'd0;
                ex_is_load = 1'b1;
                id_rs1     = 5'd0;
                id_rs2     = 5'd0;
            end
            default: ;
        endcase
        e.idx = vec_idx; e.ca = ca; e.cb = cb;
        e.sa = sa; e.fa = fa; e.ra = ra; e.sb = sb; e.fb = fb; e.rb = rb;
        exp_q.push_back(e);
        vec_idx++;
    endtask

    initial begin
        rst = 1'b1; wb_valid = 1'b0; wb_ebreak = 1'b0;
        id_rs1 = '0; id_rs2 = '0; id_uses_rs1 = 1'b0; id_uses_rs2 = 1'b0;
        ex_rd = '0; ex_is_load = 1'b0; ex_nop = 1'b0; ex_redirect = 1'b0;
        repeat (2) @(posedge clk);

        // Reset state, then load-use with 1 and 2 bubbles
        step(P_IDLE,      0, 0, 1, C_RST,   C_RST,   0, 0, 0, 0, 0, 0);
        step(P_IDLE,      0, 0, 0, C_RUN,   C_RUN,   0, 0, 0, 0, 0, 0);
        step(P_HAZ,       0, 0, 0, C_STALL, C_STALL, 0, 0, 0, 0, 0, 0);
        step(P_LD_NOP,    0, 0, 0, C_RUN,   C_STALL, 1, 0, 0, 1, 0, 0);
        step(P_IDLE,      0, 0, 0, C_RUN,   C_RUN,   1, 0, 0, 2, 0, 0);
        // Non-hazards: load to x0, source not used
        step(P_LD_X0,     0, 0, 0, C_RUN,   C_RUN,   1, 0, 0, 2, 0, 0);
        step(P_NOUSE,     0, 0, 0, C_RUN,   C_RUN,   1, 0, 0, 2, 0, 0);
        // rs2 hazard
        step(P_HAZ_RS2,   0, 0, 0, C_STALL, C_STALL, 1, 0, 0, 2, 0, 0);
        step(P_LD_NOP,    0, 0, 0, C_RUN,   C_STALL, 2, 0, 0, 3, 0, 0);
        // Redirect beats hazard
        step(P_REDIR_HAZ, 0, 0, 0, C_FLUSH, C_FLUSH, 2, 0, 0, 4, 0, 0);
        step(P_IDLE,      0, 0, 0, C_RUN,   C_RUN,   2, 1, 0, 4, 1, 0);
        // 20 retirements; CNT_W=4 instance saturates at 15
        for (int k = 0; k < 20; k++)
            step(P_IDLE, 1, 0, 0, C_RUN, C_RUN, 2, 1, k, 4, 1, (k > 15) ? 15 : k);
        // EBREAK retiring together with redirect+hazard: halt wins
        step(P_REDIR_HAZ, 1, 1, 0, C_STALL, C_STALL, 2, 1, 20, 4, 1, 15);
        for (int k = 0; k < 10; k++)
            step((k % 2 == 0) ? P_HAZ : P_REDIR_HAZ, 0, 0, 0, C_HALT, C_HALT,
                 2, 1, 21, 4, 1, 15);
        step(P_IDLE,      1, 0, 0, C_HALT,  C_HALT,  2, 1, 21, 4, 1, 15);
        // Reset during HALT
        step(P_IDLE,      0, 0, 1, C_RSTH,  C_RSTH,  2, 1, 22, 4, 1, 15);
        step(P_IDLE,      0, 0, 0, C_RUN,   C_RUN,   0, 0, 0, 0, 0, 0);
        // Reset during LU_STALL of the 2-bubble instance
        step(P_HAZ,       0, 0, 0, C_STALL, C_STALL, 0, 0, 0, 0, 0, 0);
        step(P_HAZ,       0, 0, 1, C_RST,   C_RST,   1, 0, 0, 1, 0, 0);
        step(P_LD_NOP,    0, 0, 0, C_RUN,   C_RUN,   0, 0, 0, 0, 0, 0);
        step(P_IDLE,      0, 0, 0, C_RUN,   C_RUN,   0, 0, 0, 0, 0, 0);

        repeat (3) @(posedge clk);
        @(negedge clk);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain pending=%0d required=0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
